// File: rtl/pixel_batch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_batch_scheduler_if
// Description : Bundles the engine handshake and pixel-FIFO signals around
//               the pixel batch scheduler.
//               master : scheduler side (launch, coordinates, enqueue)
//               slave  : engine/FIFO/display side (done, FIFO flags, dequeue)
// Ports       : batch_start, batch_x, batch_y, frame_num, fifo_enqueue
//               (master -> slave); batch_done, fifo_empty, fifo_almost_empty,
//               pixel_dequeue (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_batch_scheduler_if #(
    parameter int COORD_WIDTH = 10,
    parameter int FRAME_WIDTH = 16
);
    logic                   batch_start;
    logic [COORD_WIDTH-1:0] batch_x;
    logic [COORD_WIDTH-1:0] batch_y;
    logic [FRAME_WIDTH-1:0] frame_num;
    logic                   batch_done;
    logic                   fifo_enqueue;
    logic                   fifo_empty;
    logic                   fifo_almost_empty;
    logic                   pixel_dequeue;

    modport master (
        output batch_start, batch_x, batch_y, frame_num, fifo_enqueue,
        input  batch_done, fifo_empty, fifo_almost_empty, pixel_dequeue
    );

    modport slave (
        input  batch_start, batch_x, batch_y, frame_num, fifo_enqueue,
        output batch_done, fifo_empty, fifo_almost_empty, pixel_dequeue
    );
endinterface
`default_nettype wire

// File: rtl/pixel_batch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_batch_scheduler
// Description : Launches one batch of NUM_PIXELS adjacent pixels at a time on
//               the compute engine, loads each finished batch into the
//               parallel-load pixel FIFO only when no unread pixel would be
//               overwritten, tracks raster position / frame number and flags
//               display underruns.
// Ports       : clk, reset_n (async, active-low)
//               enable         - permits new launches
//               frame_sync     - start-of-vblank pulse, forces a resync
//               underrun_clear - clears the sticky underrun flag
//               busy           - scheduler not idle
//               underrun       - sticky stale-pixel flag
//               bus            - engine handshake + FIFO signals (master)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_batch_scheduler #(
    parameter int NUM_PIXELS  = 16,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int COORD_WIDTH = 10,
    parameter int FRAME_WIDTH = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  enable,
    input  wire logic                  frame_sync,
    input  wire logic                  underrun_clear,
    output logic                       busy,
    output logic                       underrun,
    pixel_batch_scheduler_if.master    bus
);

    localparam logic [COORD_WIDTH-1:0] C_X_STEP    = COORD_WIDTH'(NUM_PIXELS);
    localparam logic [COORD_WIDTH-1:0] C_X_LAST    = COORD_WIDTH'(H_VISIBLE - NUM_PIXELS);
    localparam logic [COORD_WIDTH-1:0] C_Y_LAST    = COORD_WIDTH'(V_VISIBLE - 1);
    localparam logic [COORD_WIDTH-1:0] C_Y_ONE     = COORD_WIDTH'(1);
    localparam logic [FRAME_WIDTH-1:0] C_FRAME_ONE = FRAME_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_READY  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_batch_start;
    logic [COORD_WIDTH-1:0] r_x;
    logic [COORD_WIDTH-1:0] r_y;
    logic [FRAME_WIDTH-1:0] r_frame;
    logic                   r_resync_pending;
    logic                   r_underrun;
    logic                   w_space_ok;
    logic                   w_enqueue;
    logic                   w_line_end;
    logic                   w_frame_end;
    logic                   w_to_origin;

    // A load replaces the whole FIFO, so it is only safe once the last pixel
    // has gone or is leaving in this very cycle.
    assign w_space_ok  = bus.fifo_empty | (bus.fifo_almost_empty & bus.pixel_dequeue);
    assign w_enqueue   = (r_state == S_READY) & bus.batch_done & w_space_ok;
    assign w_line_end  = (r_x == C_X_LAST);
    assign w_frame_end = w_line_end & (r_y == C_Y_LAST);
    // Either a pending resync or a natural frame wrap sends the next batch
    // back to the origin of a new frame.
    assign w_to_origin = r_resync_pending | w_frame_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_batch_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_batch_start = 1'b1;
                w_state_next  = S_BUSY;
            end
            S_BUSY: begin
                if (bus.batch_done) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                if (w_enqueue) begin
                    w_state_next = enable ? S_LAUNCH : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Raster position and frame counter advance only on the enqueue cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else if (w_enqueue) begin
            if (w_to_origin) begin
                r_x     <= '0;
                r_y     <= '0;
                r_frame <= r_frame + C_FRAME_ONE;
            end else if (w_line_end) begin
                r_x <= '0;
                r_y <= r_y + C_Y_ONE;
            end else begin
                r_x <= r_x + C_X_STEP;
            end
        end
    end

    // An advance that already lands on a new frame consumes any pending or
    // coincident frame_sync, so the frame number never double-increments.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resync_pending <= 1'b0;
        end else if (w_enqueue && w_to_origin) begin
            r_resync_pending <= 1'b0;
        end else if (frame_sync) begin
            r_resync_pending <= 1'b1;
        end
    end

    // The FIFO still presents its old head during a load, so a same-cycle
    // enqueue does not hide an underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (underrun_clear) begin
            r_underrun <= 1'b0;
        end else if (bus.pixel_dequeue && bus.fifo_empty) begin
            r_underrun <= 1'b1;
        end
    end

    assign bus.batch_start  = w_batch_start;
    assign bus.batch_x      = r_x;
    assign bus.batch_y      = r_y;
    assign bus.frame_num    = r_frame;
    assign bus.fifo_enqueue = w_enqueue;
    assign busy             = (r_state != S_IDLE);
    assign underrun         = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pixel_batch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_batch_scheduler
// Description : Self-checking bench for pixel_batch_scheduler. A transaction
//               level model (expected raster position, resync flag, batch
//               in flight / result waiting) predicts every output each cycle.
//               The frame is shortened to 120 lines to bound run time; the
//               wrap behaviour is identical.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_batch_scheduler;

    localparam int NP = 16;
    localparam int HV = 640;
    localparam int VV = 120;
    localparam int CW = 10;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;
    logic frame_sync = 1'b0;
    logic underrun_clear = 1'b0;
    logic busy;
    logic underrun;

    always #5 clk = ~clk;

    pixel_batch_scheduler_if #(.COORD_WIDTH(CW), .FRAME_WIDTH(FW)) bus ();

    pixel_batch_scheduler #(
        .NUM_PIXELS(NP), .H_VISIBLE(HV), .V_VISIBLE(VV),
        .COORD_WIDTH(CW), .FRAME_WIDTH(FW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .frame_sync(frame_sync),
        .underrun_clear(underrun_clear),
        .busy(busy),
        .underrun(underrun),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model
    int mx, my, mf;
    bit mpend, m_launch, m_in, m_ready, mu;
    // engine model
    int eng_cnt;
    int lat;
    // bookkeeping / last sampled values
    int n_enq;
    int cyc;
    int s_cyc, s_x, s_y, s_f;
    bit s_enq, s_start, s_busy, s_under;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mf = 0;
        mpend = 0; m_launch = 0; m_in = 0; m_ready = 0; mu = 0;
        eng_cnt = 0;
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic tick();
        bit space_ok, exp_enq, wrap, nl, ni, nr, done_n;
        #2;
        space_ok = bus.fifo_empty | (bus.fifo_almost_empty & bus.pixel_dequeue);
        exp_enq  = m_ready & bus.batch_done & space_ok;
        chk("batch_start",  32'(bus.batch_start),  32'(m_launch));
        chk("fifo_enqueue", 32'(bus.fifo_enqueue), 32'(exp_enq));
        chk("busy",         32'(busy),             32'(m_launch | m_in));
        chk("batch_x",      32'(bus.batch_x),      mx);
        chk("batch_y",      32'(bus.batch_y),      my);
        chk("frame_num",    32'(bus.frame_num),    mf);
        chk("underrun",     32'(underrun),         32'(mu));
        s_enq = bus.fifo_enqueue; s_start = bus.batch_start; s_busy = busy;
        s_under = underrun; s_x = bus.batch_x; s_y = bus.batch_y;
        s_f = bus.frame_num; s_cyc = cyc;
        if (s_enq) n_enq++;

        // raster rules
        wrap = 0;
        if (exp_enq) begin
            if (mpend) begin
                mx = 0; my = 0; mf = (mf + 1) % 65536;
            end else if (mx + NP == HV && my == VV - 1) begin
                mx = 0; my = 0; mf = (mf + 1) % 65536; wrap = 1;
            end else if (mx + NP == HV) begin
                mx = 0; my = my + 1;
            end else begin
                mx = mx + NP;
            end
            mpend = (mpend || wrap) ? 1'b0 : frame_sync;
        end else if (frame_sync) begin
            mpend = 1;
        end
        if (underrun_clear) mu = 0;
        else if (bus.pixel_dequeue && bus.fifo_empty) mu = 1;

        // batch life cycle: launch -> in flight -> result waiting -> enqueued
        nl = enable & (exp_enq | (!m_in & !m_launch));
        ni = m_launch | (m_in & !exp_enq);
        nr = m_in & !exp_enq & (m_ready | bus.batch_done);
        m_launch = nl; m_in = ni; m_ready = nr;

        // engine: result valid lat cycles after launch, held until acked
        done_n = bus.batch_done & !bus.fifo_enqueue;
        if (bus.batch_start) eng_cnt = lat;
        if (eng_cnt == 1) begin
            done_n = 1; eng_cnt = 0;
        end else if (eng_cnt > 1) begin
            eng_cnt--;
        end
        @(negedge clk);
        bus.batch_done = done_n;
        cyc++;
    endtask

    task automatic run_until_start(input int max, output bit found);
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            tick();
            if (s_start) found = 1;
        end
        chk("start_timeout", 32'(found), 1);
    endtask

    task automatic fast_inputs();
        bus.fifo_empty = 1; bus.fifo_almost_empty = 0; bus.pixel_dequeue = 0;
        frame_sync = 0; underrun_clear = 0; lat = 1;
    endtask

    // Asserts reset mid-cycle and checks outputs before the next clock edge.
    task automatic do_reset_async();
        #3;
        reset_n = 0;
        bus.batch_done = 0;
        #1;
        chk("rst_batch_start",  32'(bus.batch_start),  0);
        chk("rst_batch_x",      32'(bus.batch_x),      0);
        chk("rst_batch_y",      32'(bus.batch_y),      0);
        chk("rst_frame_num",    32'(bus.frame_num),    0);
        chk("rst_fifo_enqueue", 32'(bus.fifo_enqueue), 0);
        chk("rst_busy",         32'(busy),             0);
        chk("rst_underrun",     32'(underrun),         0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1;
        cyc = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found, sent;
        int e0, target, guard;

        bus.batch_done = 0; bus.fifo_empty = 1; bus.fifo_almost_empty = 0;
        bus.pixel_dequeue = 0;
        n_enq = 0; cyc = 0; lat = 2;
        model_reset();

        // power-on reset, then first batches with a 2-cycle engine
        #1 reset_n = 0;
        @(negedge clk);
        do_reset_async();
        enable = 1; lat = 2;
        run_until_start(10, found);
        chk("first_start_cycle", s_cyc, 1);
        chk("first_x", s_x, 0);
        chk("first_y", s_y, 0);
        run_until_start(10, found);
        chk("second_x", s_x, 16);
        chk("second_y", s_y, 0);

        // result waits in READY while one unread pixel remains
        lat = 1;
        run_until_start(10, found);
        bus.fifo_empty = 0; bus.fifo_almost_empty = 1; bus.pixel_dequeue = 0;
        e0 = n_enq;
        for (int i = 0; i < 6; i++) tick();
        chk("hold_no_enqueue", n_enq, e0);
        bus.pixel_dequeue = 1;
        tick();
        chk("dequeue_enqueue", 32'(s_enq), 1);
        bus.pixel_dequeue = 0;
        tick();
        chk("enqueue_one_cycle", 32'(s_enq), 0);

        // end of first line
        fast_inputs();
        guard = 0;
        while (n_enq < 40 && guard < 500) begin tick(); guard++; end
        run_until_start(10, found);
        chk("line2_x", s_x, 0);
        chk("line2_y", s_y, 1);

        // frame_sync while a batch is in flight at (320,100)
        guard = 0;
        do begin
            run_until_start(20, found);
            guard++;
        end while (found && !(s_x == 320 && s_y == 100) && guard < 5000);
        chk("reach_320_100", 32'(s_x == 320 && s_y == 100), 1);
        e0 = n_enq;
        frame_sync = 1;
        tick();
        frame_sync = 0;
        run_until_start(20, found);
        chk("resync_inflight_enq", n_enq, e0 + 1);
        chk("resync_x", s_x, 0);
        chk("resync_y", s_y, 0);
        chk("resync_frame", s_f, 1);

        // full frame, with frame_sync coincident with the natural wrap
        target = n_enq + (HV / NP) * VV;
        sent = 0; guard = 0;
        while (n_enq < target && guard < 30000) begin
            frame_sync = m_ready && bus.batch_done && mx == HV - NP && my == VV - 1;
            if (frame_sync) sent = 1;
            tick();
            frame_sync = 0;
            guard++;
        end
        chk("wrap_sync_sent", 32'(sent), 1);
        run_until_start(20, found);
        chk("wrap_x", s_x, 0);
        chk("wrap_y", s_y, 0);
        chk("wrap_frame", s_f, 2);
        run_until_start(20, found);
        chk("after_wrap_x", s_x, 16);
        chk("after_wrap_frame", s_f, 2);

        // enable low: current batch finishes, scheduler idles, coords kept
        enable = 0;
        guard = 0;
        do begin tick(); guard++; end while (!s_enq && guard < 20);
        for (int i = 0; i < 3; i++) tick();
        chk("idle_busy", 32'(s_busy), 0);
        chk("idle_x", s_x, 32);
        enable = 1;

        // sticky underrun and clear priority
        bus.pixel_dequeue = 1;
        tick();
        bus.pixel_dequeue = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("underrun_sticky", 32'(s_under), 1);
        bus.pixel_dequeue = 1; underrun_clear = 1;
        tick();
        bus.pixel_dequeue = 0; underrun_clear = 0;
        tick();
        chk("underrun_clear_prio", 32'(s_under), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.fifo_empty        = ($urandom_range(0, 3) == 0);
            bus.fifo_almost_empty = !bus.fifo_empty && ($urandom_range(0, 1) == 0);
            bus.pixel_dequeue     = $urandom_range(0, 1);
            frame_sync            = ($urandom_range(0, 40) == 0);
            underrun_clear        = ($urandom_range(0, 15) == 0);
            enable                = ($urandom_range(0, 7) != 0);
            lat                   = $urandom_range(1, 4);
            tick();
        end

        // reset while busy at x=48
        fast_inputs();
        enable = 1;
        bus.pixel_dequeue = 1;
        tick();
        bus.pixel_dequeue = 0;
        guard = 0;
        do begin
            run_until_start(20, found);
            guard++;
        end while (found && s_x != 48 && guard < 200);
        chk("reach_x48", s_x, 48);
        do_reset_async();
        run_until_start(10, found);
        chk("post_rst_cycle", s_cyc, 1);
        chk("post_rst_x", s_x, 0);
        chk("post_rst_y", s_y, 0);
        chk("post_rst_frame", s_f, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_batch_scheduler.md
Name: pixel_batch_scheduler

Overview:
- Sequences the parallel pixel compute engine against the downstream pixel FIFO, a 16-wide parallel-load FIFO with a serial shift-out.
- Launches one batch of NUM_PIXELS horizontally adjacent pixels at a time and tracks raster position and frame number.
- Loads the FIFO only when loading cannot overwrite unread pixels, and flags display underruns.
- Sits between the compute engine and the pixel FIFO; the display timing generator supplies pixel_dequeue and frame_sync.

Parameters:
NUM_PIXELS, 16, pixels per batch; equals the FIFO depth.
H_VISIBLE, 640, visible pixels per line; must be a multiple of NUM_PIXELS.
V_VISIBLE, 480, visible lines per frame.
COORD_WIDTH, 10, width of the x and y coordinates.
FRAME_WIDTH, 16, width of the frame counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  permits new batch launches
frame_sync  in  1  one-cycle pulse at start of vertical blank
pixel_dequeue  in  1  display consumes the FIFO head this cycle; also drives the FIFO dequeue
fifo_empty  in  1  from pixel FIFO
fifo_almost_empty  in  1  from pixel FIFO; high when exactly 1 pixel remains
batch_start  out  1  one-cycle launch pulse to the engine
batch_x  out  COORD_WIDTH  x of the leftmost pixel in the current batch
batch_y  out  COORD_WIDTH  y of the current batch
frame_num  out  FRAME_WIDTH  frame index of the current batch
batch_done  in  1  engine result valid; held until acknowledged
fifo_enqueue  out  1  parallel-load strobe to the FIFO; doubles as the acknowledge to the engine
busy  out  1  high in any state other than IDLE
underrun  out  1  sticky underrun flag
underrun_clear  in  1  clears underrun

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
  - Reset values: all outputs 0; state IDLE; resync_pending 0.
  - Reset mid-batch abandons the batch; the engine is reset by the same reset_n.
- IDLE: if enable is high, go to LAUNCH.
- LAUNCH: batch_start=1 for exactly one cycle. batch_x, batch_y and frame_num are stable from this cycle until the next advance. Then go to BUSY.
- BUSY: wait for batch_done=1, then go to READY. batch_start is never asserted here.
- READY: the result is held by the engine. Compute space_ok = fifo_empty | (fifo_almost_empty & pixel_dequeue).
  - fifo_enqueue is combinational and equals (state==READY) & batch_done & space_ok.
  - Reason: an enqueue overwrites the whole FIFO, so it is allowed only when the last pixel is gone or is being read in the same cycle.
- On the cycle fifo_enqueue=1, coordinates advance (registered):
  - If resync_pending: x=0, y=0, frame_num+1, resync_pending cleared.
  - Else if x+NUM_PIXELS==H_VISIBLE and y==V_VISIBLE-1: x=0, y=0, frame_num+1. frame_num wraps modulo 2^FRAME_WIDTH.
  - Else if x+NUM_PIXELS==H_VISIBLE: x=0, y+1.
  - Else: x+NUM_PIXELS.
- After the enqueue cycle: next state is LAUNCH if enable is high, else IDLE.
- Batch throughput: at most one launch per enqueue; the LAUNCH→BUSY→READY minimum is 3 cycles.
- frame_sync:
  - Sets resync_pending unless the advance happening in the same cycle already produced a natural frame wrap; in that case it is ignored, so frame_num never double-increments.
  - frame_sync coincident with a resync advance is consumed by that advance; resync_pending ends 0.
  - A batch in flight is never aborted; the resync takes effect at its advance.
- enable low: the current batch completes and is enqueued; no new launch. The state returns to IDLE, busy drops, and coordinates are retained.
- underrun: set on pixel_dequeue & fifo_empty (stale pixel displayed).
  - underrun_clear has priority over a simultaneous set.
  - An enqueue in the same cycle does not mask an underrun, because the FIFO shows its old head that cycle.
- Invariant: fifo_enqueue is never high while batch_done is low or while state is not READY.

Test Plan:
- Reset, enable=1, engine returns batch_done 2 cycles after batch_start, fifo_empty=1 → first batch_start at cycle 1 with x=0,y=0; fifo_enqueue when batch_done rises; next launch x=16,y=0.
- Hold fifo_almost_empty=1, pixel_dequeue=0 with a result in READY → no enqueue. Pulse pixel_dequeue → fifo_enqueue is high in that same cycle only.
- Run 40 batches → 41st launch has x=0, y=1. Run the full frame → after 40×480 enqueues, x=0, y=0, frame_num=1.
- frame_sync at x=320,y=100 while BUSY → the in-flight batch is enqueued, the next launch is x=0,y=0 with frame_num+1. frame_sync on the natural-wrap enqueue cycle → frame_num increments exactly once.
- pixel_dequeue with fifo_empty=1 → underrun=1 and stays set. underrun_clear with a simultaneous set → underrun=0.
- reset_n low while BUSY at x=48 → all outputs 0 immediately, asynchronously. After release with enable=1 → launch at x=0,y=0, frame_num=0.
